// File: rtl/cnt_fnd_ctrl.sv
// Binary-to-BCD converter (shift-add-3, 9-cycle period) driving a 3-digit multiplexed
// 7-segment display with leading-zero blanking.
module cnt_fnd_ctrl #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  cnt,
   output logic [11:0] bcd,
   output logic        conv_done,
   output logic [2:0]  digit_sel,
   output logic [6:0]  seg
);

   localparam int unsigned ScanW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

   state_e       r_state, w_state_nxt;
   logic [6:0]   r_shift, w_shift_nxt;
   logic [11:0]  r_scratch, w_scratch_nxt;
   logic [11:0]  w_adj;
   logic [2:0]   r_shcnt, w_shcnt_nxt;
   logic [11:0]  r_bcd, w_bcd_nxt;
   logic         r_done, w_done_nxt;

   logic [ScanW-1:0] r_scan;
   logic [1:0]       r_idx;
   logic [3:0]       w_nib;
   logic             w_blank;
   logic [6:0]       w_seg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_shift   <= '0;
         r_scratch <= '0;
         r_shcnt   <= '0;
         r_bcd     <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_scratch <= w_scratch_nxt;
         r_shcnt   <= w_shcnt_nxt;
         r_bcd     <= w_bcd_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Add-3 correction so each nibble stays within 0..9 after the following shift
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < 3; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_scratch_nxt = r_scratch;
      w_shcnt_nxt   = r_shcnt;
      w_bcd_nxt     = r_bcd;
      w_done_nxt    = 1'b0;
      case (r_state)
         StIdle: begin
            w_shift_nxt   = cnt;
            w_scratch_nxt = '0;
            w_shcnt_nxt   = '0;
            w_state_nxt   = StConv;
         end
         StConv: begin
            {w_scratch_nxt, w_shift_nxt} = {w_adj[10:0], r_shift, 1'b0};
            w_shcnt_nxt = r_shcnt + 3'd1;
            if (r_shcnt == 3'd6) begin
               w_state_nxt = StLoad;
            end
         end
         StLoad: begin
            w_bcd_nxt   = r_scratch;
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan <= '0;
         r_idx  <= 2'd0;
      end else if (r_scan == ScanW'(SCAN_DIV - 1)) begin
         r_scan <= '0;
         r_idx  <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
         r_scan <= r_scan + 1'b1;
      end
   end

   always_comb begin
      w_nib   = r_bcd[3:0];
      w_blank = 1'b0;
      case (r_idx)
         2'd1: begin
            w_nib   = r_bcd[7:4];
            w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
         end
         2'd2: begin
            w_nib   = r_bcd[11:8];
            w_blank = (r_bcd[11:8] == 4'd0);
         end
         default: ;
      endcase
      case (w_nib)
         4'd0:    w_seg = 7'h3F;
         4'd1:    w_seg = 7'h06;
         4'd2:    w_seg = 7'h5B;
         4'd3:    w_seg = 7'h4F;
         4'd4:    w_seg = 7'h66;
         4'd5:    w_seg = 7'h6D;
         4'd6:    w_seg = 7'h7D;
         4'd7:    w_seg = 7'h07;
         4'd8:    w_seg = 7'h7F;
         4'd9:    w_seg = 7'h6F;
         default: w_seg = 7'h00;
      endcase
      if (w_blank) begin
         w_seg = 7'h00;
      end
   end

   always_comb begin
      case (r_idx)
         2'd0:    digit_sel = 3'b110;
         2'd1:    digit_sel = 3'b101;
         default: digit_sel = 3'b011;
      endcase
   end

   assign seg       = w_seg;
   assign bcd       = r_bcd;
   assign conv_done = r_done;

endmodule

// File: tb/tb_cnt_fnd_ctrl.sv
// Self-checking bench for cnt_fnd_ctrl: vector table plus a scoreboard of captured counts.
module tb_cnt_fnd_ctrl;

   logic        clk;
   logic        rst_n;
   logic [6:0]  cnt;
   logic [11:0] bcd;
   logic        conv_done;
   logic [2:0]  digit_sel;
   logic [6:0]  seg;

   cnt_fnd_ctrl #(.SCAN_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt       (cnt),
      .bcd       (bcd),
      .conv_done (conv_done),
      .digit_sel (digit_sel),
      .seg       (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  cnt;
      logic [11:0] bcd;
      logic [6:0]  seg_h;
      logic [6:0]  seg_t;
      logic [6:0]  seg_o;
   } vec_t;

   vec_t        vecs[7];
   int          total;
   int          bad;
   int          phase;
   int          m_scan;
   int          m_idx;
   logic [11:0] cur_bcd;
   logic [11:0] sb_q[$];
   bit          exp_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input logic [6:0] v);
      int n;
      n = int'(v);
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic [6:0] dec7(input logic [3:0] d);
      logic [6:0] tbl[10];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return (d > 4'd9) ? 7'h00 : tbl[d];
   endfunction

   function automatic logic [6:0] seg_exp(input logic [11:0] b, input int idx);
      if (idx == 2) return (b[11:8] == 0) ? 7'h00 : dec7(b[11:8]);
      if (idx == 1) return (b[11:8] == 0 && b[7:4] == 0) ? 7'h00 : dec7(b[7:4]);
      return dec7(b[3:0]);
   endfunction

   function automatic logic [2:0] sel_exp(input int idx);
      if (idx == 0) return 3'b110;
      if (idx == 1) return 3'b101;
      return 3'b011;
   endfunction

   task automatic model_reset();
      phase   = 0;
      m_scan  = 0;
      m_idx   = 0;
      cur_bcd = 12'h000;
      sb_q.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      exp_done = 1'b0;
      if (rst_n) begin
         if (phase == 0) sb_q.push_back(to_bcd(cnt));
         if (phase == 8) exp_done = 1'b1;
         phase = (phase == 8) ? 0 : phase + 1;
         if (m_scan == 3) begin
            m_scan = 0;
            m_idx  = (m_idx == 2) ? 0 : m_idx + 1;
         end else begin
            m_scan++;
         end
      end
      @(negedge clk);
      chk("conv_done", 32'(conv_done), 32'(exp_done));
      if (conv_done) begin
         chk("sb_depth", sb_q.size(), 1);
         if (sb_q.size() > 0) cur_bcd = sb_q.pop_front();
         chk("bcd_conv", 32'(bcd), 32'(cur_bcd));
      end else begin
         chk("bcd_hold", 32'(bcd), 32'(cur_bcd));
      end
      chk("digit_sel", 32'(digit_sel), 32'(sel_exp(m_idx)));
      chk("seg", 32'(seg), 32'(seg_exp(cur_bcd, m_idx)));
   endtask

   // Asynchronous reset entry, checked before any clock edge
   task automatic reset_enter();
      rst_n = 1'b0;
      #1;
      chk("rst_bcd", 32'(bcd), 32'h000);
      chk("rst_conv_done", 32'(conv_done), 32'h0);
      chk("rst_digit_sel", 32'(digit_sel), 32'(3'b110));
      chk("rst_seg", 32'(seg), 32'h3F);
      model_reset();
   endtask

   initial begin
      int n_done;
      total = 0;
      bad   = 0;
      cnt   = 7'd127;
      vecs[0] = '{7'd127, 12'h127, 7'h06, 7'h5B, 7'h07};
      vecs[1] = '{7'd5,   12'h005, 7'h00, 7'h00, 7'h6D};
      vecs[2] = '{7'd100, 12'h100, 7'h06, 7'h3F, 7'h3F};
      vecs[3] = '{7'd0,   12'h000, 7'h00, 7'h00, 7'h3F};
      vecs[4] = '{7'd10,  12'h010, 7'h00, 7'h06, 7'h3F};
      vecs[5] = '{7'd99,  12'h099, 7'h00, 7'h6F, 7'h6F};
      vecs[6] = '{7'd42,  12'h042, 7'h00, 7'h66, 7'h5B};

      reset_enter();
      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         cnt    = vecs[i].cnt;
         n_done = 0;
         for (int k = 0; k < 20 && n_done < 2; k++) begin
            tick();
            if (conv_done) n_done++;
         end
         chk("vec_done_seen", n_done, 2);
         chk("vec_bcd", 32'(bcd), 32'(vecs[i].bcd));
         for (int k = 0; k < 12; k++) begin
            tick();
            case (digit_sel)
               3'b011:  chk("vec_seg_h", 32'(seg), 32'(vecs[i].seg_h));
               3'b101:  chk("vec_seg_t", 32'(seg), 32'(vecs[i].seg_t));
               default: chk("vec_seg_o", 32'(seg), 32'(vecs[i].seg_o));
            endcase
         end
      end

      // Sweep: each value is presented on the capture edge, then disturbed during CONV
      for (int v = 0; v < 128; v++) begin
         while (phase != 0) tick();
         cnt = 7'(v);
         tick();
         cnt = ~7'(v);
         for (int k = 0; k < 8; k++) tick();
      end

      // Abort mid-CONV, then restart on the first edge after release
      while (phase != 0) tick();
      cnt = 7'd33;
      tick();
      cnt = 7'd50;
      tick();
      tick();
      tick();
      reset_enter();
      tick();
      tick();
      cnt   = 7'd77;
      rst_n = 1'b1;
      tick();
      cnt = 7'd12;
      for (int k = 0; k < 8; k++) tick();
      chk("restart_bcd", 32'(bcd), 32'h077);
      for (int k = 0; k < 9; k++) tick();
      chk("restart_bcd2", 32'(bcd), 32'h012);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
